// File: rtl/ballot_collector.sv
// ballot_collector
// ----------------
// Front end for a 4-input combinational voter. A round opens on `start`.
// During the collection window each of the 4 voters offers one ballot over a
// valid/ready handshake. The round closes when all four voters have voted or
// when the window times out. A voter that has not voted by then is marked as
// abstaining. The resulting ballot/abstain vectors are held stable between
// rounds so that the downstream voter always sees a steady I[3:0].
//
// Optional build macro: RESULT_LATCH_EN. When it is defined, the voter
// decision O[3:1] (result_in) is captured one cycle after ballot_valid. When
// it is undefined, result and result_valid are tied to 0.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   start         pulse: opens a round when idle (ignored while busy)
//   vote_valid    ballot offered this cycle
//   vote_id[1:0]  index of the voting voter
//   vote_val      ballot value (1 = yes)
//   vote_ready    collector accepts ballots this cycle (collect phase only)
//   ballot[3:0]   vector to voter I[3:0]; abstaining bits are 0
//   abstain[3:0]  bit k = voter k did not vote in the last round
//   ballot_valid  one-cycle pulse when ballot/abstain update
//   busy          high while collecting or issuing
//   dup_err       one-cycle pulse after a duplicate ballot was consumed
//   result_in     voter decision O[3:1]
//   result        latched decision
//   result_valid  one-cycle pulse when result updates
//
// Handshake: a ballot transfers on any rising edge where vote_valid and
// vote_ready are both high. vote_ready depends only on the collector state,
// never on vote_valid. A transferred ballot is always consumed, including a
// duplicate, which is discarded; the first value from a voter stands.
module ballot_collector #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       vote_valid,
  input  logic [1:0] vote_id,
  input  logic       vote_val,
  output logic       vote_ready,
  output logic [3:0] ballot,
  output logic [3:0] abstain,
  output logic       ballot_valid,
  output logic       busy,
  output logic       dup_err,
  input  logic [2:0] result_in,
  output logic [2:0] result,
  output logic       result_valid
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_ISSUE   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [3:0]       r_shadow;
  logic [3:0]       r_rcv;
  logic [3:0]       r_ballot;
  logic [3:0]       r_abstain;
  logic             r_dup_err;

  logic             w_accept;
  logic             w_dup;
  logic             w_timeout;
  logic             w_close;
  logic [3:0]       w_shadow_nxt;
  logic [3:0]       w_rcv_nxt;

  // Ballot bookkeeping. The *_nxt vectors include a ballot accepted on this
  // edge. As a result, a vote arriving in the same cycle as the timeout (or
  // the vote that completes the set) is part of the issued vector.
  always_comb begin
    w_accept     = (r_state == S_COLLECT) && vote_valid;
    w_dup        = w_accept && r_rcv[vote_id];
    w_shadow_nxt = r_shadow;
    w_rcv_nxt    = r_rcv;
    if (w_accept && !w_dup) begin
      w_shadow_nxt[vote_id] = vote_val;
      w_rcv_nxt[vote_id]    = 1'b1;
    end
    // The timer counts collect cycles from 0. Closing at TIMEOUT_CYCLES-1
    // gives a window of exactly TIMEOUT_CYCLES cycles.
    w_timeout = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
    w_close   = (r_state == S_COLLECT) && ((w_rcv_nxt == 4'b1111) || w_timeout);
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_state_nxt  = r_state;
    vote_ready   = 1'b0;
    busy         = 1'b0;
    ballot_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        vote_ready = 1'b1;
        busy       = 1'b1;
        if (w_close) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        busy         = 1'b1;
        ballot_valid = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_shadow  <= 4'b0000;
      r_rcv     <= 4'b0000;
      r_ballot  <= 4'b0000;
      r_abstain <= 4'b0000;
      r_dup_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dup_err <= w_dup;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_timer  <= '0;
            r_shadow <= 4'b0000;
            r_rcv    <= 4'b0000;
          end
        end
        S_COLLECT: begin
          r_timer  <= r_timer + TMR_W'(1);
          r_shadow <= w_shadow_nxt;
          r_rcv    <= w_rcv_nxt;
          // The output vectors are loaded on the edge that enters ISSUE.
          // This way they change in the same cycle that ballot_valid is high.
          if (w_close) begin
            r_ballot  <= w_shadow_nxt & w_rcv_nxt;
            r_abstain <= ~w_rcv_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign ballot  = r_ballot;
  assign abstain = r_abstain;
  assign dup_err = r_dup_err;

`ifdef RESULT_LATCH_EN
  logic [2:0] r_result;
  logic       r_result_valid;

  // The voter is combinational on ballot. Its decision is therefore settled
  // during the ISSUE cycle and is captured on the edge that leaves ISSUE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result       <= 3'b000;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= (r_state == S_ISSUE);
      if (r_state == S_ISSUE) r_result <= result_in;
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
`else
  logic w_unused_result;
  assign w_unused_result = ^result_in;
  assign result       = 3'b000;
  assign result_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ballot_collector.sv
module tb_ballot_collector;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       vote_valid = 1'b0;
  logic [1:0] vote_id = 2'd0;
  logic       vote_val = 1'b0;
  logic [2:0] result_in = 3'b000;
  logic       vote_ready;
  logic [3:0] ballot;
  logic [3:0] abstain;
  logic       ballot_valid;
  logic       busy;
  logic       dup_err;
  logic [2:0] result;
  logic       result_valid;

  ballot_collector #(.TIMEOUT_CYCLES(T), .TMR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vote_valid(vote_valid), .vote_id(vote_id), .vote_val(vote_val),
    .vote_ready(vote_ready), .ballot(ballot), .abstain(abstain),
    .ballot_valid(ballot_valid), .busy(busy), .dup_err(dup_err),
    .result_in(result_in), .result(result), .result_valid(result_valid)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end, limit 500000 ns");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {vote_ready, busy, ballot_valid, dup_err, ballot, abstain, result, result_valid};
  endfunction

  // ---------------- reference model ----------------
  // Round-level view: a round is open for at most T collect cycles. It records
  // the first ballot of every voter. It closes when all have voted or the
  // window is used up, and is followed by a single issue cycle.
  bit         m_open = 0;
  bit         m_issuing = 0;
  int         m_age = 0;
  bit         m_have[4];
  bit         m_val[4];
  logic [3:0] e_ballot = 4'b0, e_abstain = 4'b0;
  logic [2:0] e_result = 3'b0;
  bit         e_rv = 0, e_dup = 0;

  task automatic model_step();
    int n_have;
    if (!rst_n) begin
      m_open = 0; m_issuing = 0; m_age = 0;
      e_ballot = 4'b0; e_abstain = 4'b0; e_result = 3'b0; e_rv = 0; e_dup = 0;
      return;
    end
    e_dup = 0;
    e_rv  = 0;
    if (m_issuing) begin
      m_issuing = 0;
`ifdef RESULT_LATCH_EN
      e_result = result_in;
      e_rv     = 1;
`endif
    end else if (m_open) begin
      if (vote_valid) begin
        if (m_have[vote_id]) e_dup = 1;
        else begin
          m_have[vote_id] = 1;
          m_val[vote_id]  = vote_val;
        end
      end
      m_age++;
      n_have = 0;
      for (int j = 0; j < 4; j++) n_have += int'(m_have[j]);
      if (n_have == 4 || m_age == T) begin
        m_open = 0;
        m_issuing = 1;
        for (int j = 0; j < 4; j++) begin
          e_ballot[j]  = m_have[j] && m_val[j];
          e_abstain[j] = !m_have[j];
        end
      end
    end else if (start) begin
      m_open = 1;
      m_age  = 0;
      for (int j = 0; j < 4; j++) begin m_have[j] = 0; m_val[j] = 0; end
    end
  endtask

  function automatic logic [15:0] exp_vec();
    return {m_open, m_open | m_issuing, m_issuing, e_dup, e_ballot, e_abstain, e_result, e_rv};
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge. Inputs are applied, the rising edge is taken,
  // and the outputs are compared with the model at the next falling edge.
  task automatic cycle(input bit st, input bit vv, input logic [1:0] id, input bit val);
    start = st; vote_valid = vv; vote_id = id; vote_val = val;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", dut_vec(), exp_vec());
  endtask

  // Runs one round. Voter j votes on call vk[j] (-1 = never); call 0 carries
  // start. Returns the cycle after the start edge in which ballot_valid rose.
  task automatic timed_round(input int vk[4], input bit vals[4], output int bv_at);
    bv_at = -1;
    for (int k = 0; k <= 40; k++) begin
      bit         v = 0;
      logic [1:0] id = 2'd0;
      bit         val = 0;
      for (int j = 0; j < 4; j++)
        if (vk[j] == k) begin v = 1; id = 2'(j); val = vals[j]; end
      cycle(k == 0, v, id, val);
      if (ballot_valid) begin bv_at = k + 1; break; end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         st;
    bit         vv;
    logic [1:0] id;
    bit         val;
    bit         e_ready;
    bit         e_busy;
    bit         e_bv;
    bit         e_dup;
    logic [3:0] e_ballot;
    logic [3:0] e_abstain;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int         bv_at;
    logic [15:0] d;

    // full round: id0=1 id1=0 id2=1 id3=1
    tbl[0]  = '{1, 0, 2'd0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000};
    tbl[1]  = '{0, 1, 2'd0, 1, 1, 1, 0, 0, 4'b0000, 4'b0000};
    tbl[2]  = '{0, 1, 2'd1, 0, 1, 1, 0, 0, 4'b0000, 4'b0000};
    tbl[3]  = '{0, 1, 2'd2, 1, 1, 1, 0, 0, 4'b0000, 4'b0000};
    tbl[4]  = '{0, 1, 2'd3, 1, 0, 1, 1, 0, 4'b1101, 4'b0000};
    tbl[5]  = '{0, 0, 2'd0, 0, 0, 0, 0, 0, 4'b1101, 4'b0000};
    // duplicate round: id1=1, id1=0 (dup), id0=0, id2=0, id3=0
    tbl[6]  = '{1, 0, 2'd0, 0, 1, 1, 0, 0, 4'b1101, 4'b0000};
    tbl[7]  = '{0, 1, 2'd1, 1, 1, 1, 0, 0, 4'b1101, 4'b0000};
    tbl[8]  = '{0, 1, 2'd1, 0, 1, 1, 0, 1, 4'b1101, 4'b0000};
    tbl[9]  = '{0, 1, 2'd0, 0, 1, 1, 0, 0, 4'b1101, 4'b0000};
    tbl[10] = '{0, 1, 2'd2, 0, 1, 1, 0, 0, 4'b1101, 4'b0000};
    tbl[11] = '{0, 1, 2'd3, 0, 0, 1, 1, 0, 4'b0010, 4'b0000};
    // vote_valid while idle is never acknowledged
    tbl[12] = '{0, 1, 2'd0, 1, 0, 0, 0, 0, 4'b0010, 4'b0000};
    tbl[13] = '{0, 1, 2'd1, 1, 0, 0, 0, 0, 4'b0010, 4'b0000};

    // ---- reset ----
    rst_n = 1'b0;
    @(negedge clk);
    cycle(0, 0, 2'd0, 0);
    cycle(0, 1, 2'd0, 1);
    check("reset_state", dut_vec(), 16'h0000);
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].st, tbl[i].vv, tbl[i].id, tbl[i].val);
      d = dut_vec();
      check($sformatf("vec%0d", i), {4'h0, d[15:4]},
            {4'h0, tbl[i].e_ready, tbl[i].e_busy, tbl[i].e_bv, tbl[i].e_dup,
             tbl[i].e_ballot, tbl[i].e_abstain});
    end

    // ---- timeout with only id2 and id0 voting ----
    result_in = 3'b101;
    timed_round('{2, -1, 1, -1}, '{1, 0, 1, 0}, bv_at);
    check("timeout_latency", 16'(bv_at), 16'(T + 1));
    check("timeout_vectors", {8'h0, ballot, abstain}, {8'h0, 4'b0101, 4'b1010});
    cycle(0, 0, 2'd0, 0);
`ifdef RESULT_LATCH_EN
    check("result_latch", {12'h0, result, result_valid}, {12'h0, 3'b101, 1'b1});
`else
    check("result_latch", {12'h0, result, result_valid}, 16'h0000);
`endif
    result_in = 3'b000;

    // ---- last vote lands on the timeout edge ----
    timed_round('{1, 2, 3, T}, '{1, 1, 0, 1}, bv_at);
    check("edge_vote_latency", 16'(bv_at), 16'(T + 1));
    check("edge_vote_vectors", {8'h0, ballot, abstain}, {8'h0, 4'b1011, 4'b0000});
    cycle(0, 0, 2'd0, 0);

    // ---- reset in the middle of a round ----
    cycle(1, 0, 2'd0, 0);
    cycle(0, 1, 2'd0, 1);
    cycle(0, 1, 2'd1, 1);
    rst_n = 1'b0;
    cycle(0, 1, 2'd2, 1);
    rst_n = 1'b1;
    check("mid_reset", {8'h0, busy, ballot_valid, ballot, 2'b00}, 16'h0000);
    for (int i = 0; i < 5; i++) cycle(0, 1, 2'd3, 1);
    check("mid_reset_hold", {12'h0, ballot}, 16'h0000);
    timed_round('{1, 2, 3, 4}, '{1, 1, 1, 1}, bv_at);
    check("after_reset_latency", 16'(bv_at), 16'd5);
    check("after_reset_vectors", {8'h0, ballot, abstain}, {8'h0, 4'b1111, 4'b0000});
    cycle(0, 0, 2'd0, 0);

    // ---- randomized stimulus against the model ----
    for (int i = 0; i < 2000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      result_in = 3'($urandom_range(0, 7));
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
